mux4x1_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit 4:1 mux datapath among four requesters. Each requester raises a request, holds the datapath until it signals its last beat, then releases it. The arbiter drives the mux select lines from its registered grant, so the selected data path and the grant always change together. It sits between the four source channels and the single downstream consumer of the muxed word.

---
 rtl/mux4x1_arb_pkg.sv | 29 ++
 rtl/mux4x1_arbiter_mux4x1.sv | 28 ++
 rtl/mux4x1_arbiter.sv | 132 +++++++++++++
 tb/tb_mux4x1_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux4x1_arb_pkg.sv
// Shared types and the round-robin winner search
// for the mux4x1_arbiter slice.
package mux4x1_arb_pkg;

  localparam int NREQ = 4;
  localparam logic [1:0] PTR_RST = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Scan from ptr+4 down to ptr+1 so the nearest
  // set request after ptr is written last and wins.
  function automatic logic [1:0] rr_next(
    input logic [1:0]      ptr,
    input logic [NREQ-1:0] req
  );
    logic [1:0] win;
    logic [1:0] idx;
    win = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/mux4x1_arbiter_mux4x1.sv
// Gate-level 1-bit 4:1 mux slice.
// Input index is {sel0, sel1}.
module mux4x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic sel0,
  input  logic sel1,
  output logic f
);

  logic n0;
  logic n1;
  logic t0;
  logic t1;
  logic t2;
  logic t3;

  assign n0 = ~sel0;
  assign n1 = ~sel1;
  assign t0 = n0   & n1   & i0;
  assign t1 = n0   & sel1 & i1;
  assign t2 = sel0 & n1   & i2;
  assign t3 = sel0 & sel1 & i3;
  assign f  = t0 | t1 | t2 | t3;

endmodule

// File: rtl/mux4x1_arbiter.sv
// Round-robin arbiter driving a shared W-bit 4:1 mux.
// ARB_TIMEOUT_EN adds a HOLD_MAX-cycle forced release.
module mux4x1_arbiter
  import mux4x1_arb_pkg::*;
#(
  parameter int W        = 1,
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      last,
  input  logic [W-1:0]    d0,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  input  logic [W-1:0]    d3,
  output logic [3:0]      gnt,
  output logic            sel0,
  output logic            sel1,
  output logic            valid,
`ifdef ARB_TIMEOUT_EN
  output logic            timeout,
`endif
  output logic [W-1:0]    f
);

  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("HOLD_MAX must be at least 1");
  end

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic            valid_q;
  logic            sel0_q;
  logic            sel1_q;

  logic [1:0]      win_d;
  logic            norm_d;
  logic            tmo_d;
  logic            rel_d;

  // While granted, ptr_q is the owner's index.
  assign win_d  = rr_next(ptr_q, req);
  assign norm_d = ~req[ptr_q] | last[ptr_q];
  assign rel_d  = norm_d | tmo_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt_q;
  logic          to_q;

  assign tmo_d   = (cnt_q == CMAX);
  assign timeout = to_q;
`else
  assign tmo_d   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      sel0_q  <= 1'b0;
      sel1_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      to_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            ptr_q   <= win_d;
            gnt_q   <= NREQ'(1) << win_d;
            valid_q <= 1'b1;
            sel0_q  <= win_d[1];
            sel1_q  <= win_d[0];
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        GRANT: begin
          if (rel_d) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_q    <= ~norm_d;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign sel0  = sel0_q;
  assign sel1  = sel1_q;

  for (genvar j = 0; j < W; j++) begin : g_bit
    mux4x1 u_mux (
      .i0   (d0[j]),
      .i1   (d1[j]),
      .i2   (d2[j]),
      .i3   (d3[j]),
      .sel0 (sel0_q),
      .sel1 (sel1_q),
      .f    (f[j])
    );
  end

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Scoreboard bench for mux4x1_arbiter: directed vectors
// push expectations, a monitor pops and compares.
module tb_mux4x1_arbiter;

  localparam int W  = 2;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   last;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [3:0]   gnt;
  logic         sel0;
  logic         sel1;
  logic         valid;
  logic         to;
  logic [W-1:0] f;

  always #5 clk = ~clk;

  mux4x1_arbiter #(.W(W), .HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .last    (last),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .gnt     (gnt),
    .sel0    (sel0),
    .sel1    (sel1),
    .valid   (valid),
`ifdef ARB_TIMEOUT_EN
    .timeout (to),
`endif
    .f       (f)
  );

`ifndef ARB_TIMEOUT_EN
  assign to = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]   gnt;
    logic         valid;
    logic         sel0;
    logic         sel1;
    logic [W-1:0] f;
    logic         to;
  } obs_t;

  logic [W-1:0] dv [4];
  obs_t q [$];
  obs_t mon_e;
  int   nvec = 0;
  int   nmis = 0;
  int   vid  = 0;

  function automatic obs_t cur();
    obs_t o;
    o.gnt   = gnt;
    o.valid = valid;
    o.sel0  = sel0;
    o.sel1  = sel1;
    o.f     = f;
    o.to    = to;
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t act,
                     input obs_t ex);
    nvec++;
    if (act !== ex) begin
      nmis++;
      $display("FAIL %s: got gnt=%b v=%b sel=%b%b f=%h to=%b, want gnt=%b v=%b sel=%b%b f=%h to=%b",
               nm, act.gnt, act.valid, act.sel0, act.sel1,
               act.f, act.to, ex.gnt, ex.valid, ex.sel0,
               ex.sel1, ex.f, ex.to);
    end
  endtask

  // es = {sel0, sel1}, the hand-computed owner index.
  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic et);
    obs_t e;
    req    = r;
    last   = l;
    e.gnt  = eg;
    e.valid = |eg;
    e.sel0 = es[1];
    e.sel1 = es[0];
    e.f    = dv[es];
    e.to   = et;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      vid++;
      chk($sformatf("vec%0d", vid), cur(), mon_e);
    end
  end

  obs_t rst_e;

  initial begin
    dv[0] = 2'b00;
    dv[1] = 2'b01;
    dv[2] = 2'b10;
    dv[3] = 2'b11;
    d0 = dv[0];
    d1 = dv[1];
    d2 = dv[2];
    d3 = dv[3];
    rst_e = '{gnt: 4'b0, valid: 1'b0, sel0: 1'b0,
              sel1: 1'b0, f: 2'b00, to: 1'b0};
    rst_n = 1'b0;
    req   = 4'b1111;
    last  = 4'b0000;
    repeat (2) @(negedge clk);
    chk("reset_hold", cur(), rst_e);
    rst_n = 1'b1;

    // Fairness from reset: 0,1,2,3,0 with dead cycles
    step(4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b0);
    step(4'b1111, 4'b1111, 4'b0000, 2'd1, 1'b0);
    step(4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b0);
    step(4'b1111, 4'b1111, 4'b0000, 2'd2, 1'b0);
    step(4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 4'b1111, 4'b0000, 2'd3, 1'b0);
    step(4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Single 3-beat transfer, then immediate re-request
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Early drop by requester 1, then 3 beats 0
    step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step(4'b1001, 4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);

    // Long hold by 3; others' req/last ignored
    step(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
`ifdef ARB_TIMEOUT_EN
    repeat (3) step(4'b1111, 4'b0111, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 4'b0111, 4'b0000, 2'd3, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);
`else
    repeat (5) step(4'b1111, 4'b0111, 4'b1000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);
`endif

    // Asynchronous reset in the middle of a grant to 2
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", cur(), rst_e);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(posedge clk);
    #2;
    if (q.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
